digit_serial_alu: RTL and testbench

//  Parametrised digit-serial ALU sequencer; successor of the fixed 4-bit nibble loop driven by the core control FSM.

---
 rtl/digit_serial_alu.sv | 202 ++++++++++++++++++++
 tb/tb_digit_serial_alu.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : digit_serial_alu
// Description : Digit-serial ALU, DIGIT_W bits per cycle LSB first, with word2
//               length extension and early termination for ADD/SUB.
//               Define ALU_FLAGS_EN to add the z/n/c/v flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_serial_alu #(
    parameter int XLEN    = 32,
    parameter int DIGIT_W = 4,
    localparam int c_NDIG  = XLEN / DIGIT_W,
    localparam int c_IDX_W = (c_NDIG > 1) ? $clog2(c_NDIG) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [2:0]         op,
    input  logic [c_IDX_W-1:0] num_digits_m1,
    input  logic               w2_signed,
    input  logic [XLEN-1:0]    word1,
    input  logic [XLEN-1:0]    word2,
    output logic [XLEN-1:0]    result,
    output logic               result_valid,
    output logic               busy
`ifdef ALU_FLAGS_EN
    ,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               flag_v
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_ADD   = 3'd0;
    localparam logic [2:0] c_OP_SUB   = 3'd1;
    localparam logic [2:0] c_OP_AND   = 3'd2;
    localparam logic [2:0] c_OP_OR    = 3'd3;
    localparam logic [2:0] c_OP_XOR   = 3'd4;
    localparam logic [2:0] c_OP_PASS2 = 3'd5;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(c_NDIG - 1);
    localparam logic [XLEN-1:0]    c_ONE      = XLEN'(1);

    if (XLEN % DIGIT_W != 0) begin : g_width_check
        $error("digit_serial_alu: XLEN must be a multiple of DIGIT_W");
    end

    state_t             r_state, w_state_nxt;
    logic [XLEN-1:0]    r_a, r_b, r_result;
    logic [2:0]         r_op;
    logic [c_IDX_W-1:0] r_nd, r_idx;
    logic               r_carry;

    logic               w_accept, w_run_done, w_early, w_is_arith, w_is_logic, w_sign;
    logic [XLEN-1:0]    w_ext_b, w_dig_mask, w_upper_mask, w_logic_full, w_res_nxt;
    logic [DIGIT_W-1:0] w_a_dig, w_b_dig, w_b_eff, w_bn_eff, w_logic_dig;
    logic [DIGIT_W:0]   w_sum;

    // word2 is trimmed to its significant digits and refilled with 0 or its top bit
    always_comb begin
        w_sign = 1'b0;
        for (int d = 0; d < c_NDIG; d++) begin
            if (num_digits_m1 == c_IDX_W'(d)) w_sign = word2[d*DIGIT_W + DIGIT_W - 1];
        end
        w_ext_b = '0;
        for (int i = 0; i < XLEN; i++) begin
            w_ext_b[i] = ((i / DIGIT_W) <= int'(num_digits_m1)) ? word2[i] : (w2_signed & w_sign);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        start_ready  = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_run_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                start_ready  = 1'b1;
                result_valid = 1'b1;
                w_state_nxt  = start_valid ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = start_valid && start_ready;
    assign result   = r_result;

    always_comb begin
        w_is_arith   = (r_op == c_OP_ADD) || (r_op == c_OP_SUB);
        w_is_logic   = (r_op == c_OP_AND) || (r_op == c_OP_OR) || (r_op == c_OP_XOR);
        w_a_dig      = DIGIT_W'(r_a >> (int'(r_idx) * DIGIT_W));
        w_b_dig      = DIGIT_W'(r_b >> (int'(r_idx) * DIGIT_W));
        w_bn_eff     = DIGIT_W'(r_b >> ((int'(r_idx) + 1) * DIGIT_W));
        w_b_eff      = w_b_dig;
        if (r_op == c_OP_SUB) begin
            w_b_eff  = ~w_b_dig;
            w_bn_eff = ~w_bn_eff;
        end
        w_sum        = {1'b0, w_a_dig} + {1'b0, w_b_eff} + {{DIGIT_W{1'b0}}, r_carry};
        w_dig_mask   = XLEN'({DIGIT_W{1'b1}}) << (int'(r_idx) * DIGIT_W);
        w_upper_mask = ~((c_ONE << ((int'(r_idx) + 1) * DIGIT_W)) - c_ONE);

        case (r_op)
            c_OP_AND: begin w_logic_dig = w_a_dig & w_b_dig; w_logic_full = r_a & r_b; end
            c_OP_OR:  begin w_logic_dig = w_a_dig | w_b_dig; w_logic_full = r_a | r_b; end
            c_OP_XOR: begin w_logic_dig = w_a_dig ^ w_b_dig; w_logic_full = r_a ^ r_b; end
            default:  begin w_logic_dig = '0;                w_logic_full = '0;        end
        endcase

        // Past the significant length, an all-0 digit with no carry or an all-1
        // digit with carry leaves every remaining word1 digit unchanged.
        w_early = (r_idx >= r_nd) &&
                  (((w_bn_eff == '0) && !w_sum[DIGIT_W]) || ((w_bn_eff == '1) && w_sum[DIGIT_W]));

        w_run_done = 1'b1;
        w_res_nxt  = '0;
        if (w_is_arith) begin
            w_run_done = (r_idx == c_IDX_LAST) || w_early;
            w_res_nxt  = (r_result & ~w_dig_mask) |
                         (XLEN'(w_sum[DIGIT_W-1:0]) << (int'(r_idx) * DIGIT_W));
            if (w_run_done) w_res_nxt = (w_res_nxt & ~w_upper_mask) | (r_a & w_upper_mask);
        end else if (w_is_logic) begin
            w_run_done = (r_idx == r_nd);
            w_res_nxt  = (r_result & ~w_dig_mask) |
                         (XLEN'(w_logic_dig) << (int'(r_idx) * DIGIT_W));
            if (w_run_done) w_res_nxt = (w_res_nxt & ~w_upper_mask) | (w_logic_full & w_upper_mask);
        end else if (r_op == c_OP_PASS2) begin
            w_res_nxt  = r_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_nd     <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_a      <= word1;
            r_b      <= w_ext_b;
            r_op     <= op;
            r_nd     <= num_digits_m1;
            r_idx    <= '0;
            r_carry  <= (op == c_OP_SUB);
        end else if (r_state == S_RUN) begin
            r_result <= w_res_nxt;
            r_carry  <= w_sum[DIGIT_W];
            if (!w_run_done) r_idx <= r_idx + c_IDX_W'(1);
        end
    end

`ifdef ALU_FLAGS_EN
    logic r_flag_z, r_flag_n, r_flag_c, r_flag_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_z <= 1'b0;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
            r_flag_v <= 1'b0;
        end else if ((r_state == S_RUN) && w_run_done) begin
            r_flag_z <= (w_res_nxt == '0);
            r_flag_n <= w_res_nxt[XLEN-1];
            r_flag_c <= w_is_arith && w_sum[DIGIT_W];
            r_flag_v <= w_is_arith &&
                        (r_a[XLEN-1] == (r_b[XLEN-1] ^ (r_op == c_OP_SUB))) &&
                        (w_res_nxt[XLEN-1] != r_a[XLEN-1]);
        end
    end

    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_c = r_flag_c;
    assign flag_v = r_flag_v;
`endif

endmodule
`default_nettype wire

// File: tb/tb_digit_serial_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_serial_alu
// Description : Directed-vector bench for digit_serial_alu with an arithmetic
//               reference model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_serial_alu;

    localparam int XLEN    = 32;
    localparam int DIGIT_W = 4;
    localparam int NDIG    = XLEN / DIGIT_W;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        w2_signed = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [2:0]  num_digits_m1 = 3'd0;
    logic [31:0] word1 = 32'd0;
    logic [31:0] word2 = 32'd0;
    logic        start_ready, result_valid, busy;
    logic [31:0] result;
`ifdef ALU_FLAGS_EN
    logic        flag_z, flag_n, flag_c, flag_v;
`endif

    digit_serial_alu #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .op            (op),
        .num_digits_m1 (num_digits_m1),
        .w2_signed     (w2_signed),
        .word1         (word1),
        .word2         (word2),
        .result        (result),
        .result_valid  (result_valid),
        .busy          (busy)
`ifdef ALU_FLAGS_EN
        ,
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .flag_c        (flag_c),
        .flag_v        (flag_v)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          run;
        int          ac;
        bit          z, n, c, v;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result is plain modular arithmetic; run length is the first digit past the
    // significant length whose carry out matches the uniform extension digits.
    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w2,
                                   input int nd, input bit sg);
        exp_t        e;
        logic [31:0] mask, b, beff;
        logic [63:0] full, m, cy;
        int          k;
        bit          cin;
        k    = (nd + 1) * DIGIT_W;
        mask = (k >= 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
        b    = w2 & mask;
        if (sg && w2[k-1]) b = b | ~mask;
        e.res = 32'd0; e.run = 1; e.ac = 0;
        e.z = 1'b0; e.n = 1'b0; e.c = 1'b0; e.v = 1'b0;
        case (o)
            3'd0, 3'd1: begin
                cin   = (o == 3'd1);
                beff  = cin ? ~b : b;
                full  = {32'd0, a} + {32'd0, beff} + 64'(cin);
                e.res = full[31:0];
                e.c   = full[32];
                e.v   = (a[31] == beff[31]) && (e.res[31] != a[31]);
                e.run = NDIG;
                for (int i = nd; i < NDIG - 1; i++) begin
                    m  = (64'd1 << ((i + 1) * DIGIT_W)) - 64'd1;
                    cy = (({32'd0, a} & m) + ({32'd0, beff} & m) + 64'(cin)) >> ((i + 1) * DIGIT_W);
                    if (cy[0] == beff[31]) begin
                        e.run = i + 1;
                        break;
                    end
                end
            end
            3'd2: begin e.res = a & b; e.run = nd + 1; end
            3'd3: begin e.res = a | b; e.run = nd + 1; end
            3'd4: begin e.res = a ^ b; e.run = nd + 1; end
            3'd5: e.res = b;
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    // Per-cycle compare against the expected timeline of the front transaction
    always @(negedge clk) begin
        exp_t e;
        bit   eb, ev;
        if (chk_en) begin
            eb = 1'b0;
            ev = 1'b0;
            if (q.size() > 0) begin
                e  = q[0];
                eb = (cyc >= e.ac) && (cyc < e.ac + e.run);
                ev = (cyc == e.ac + e.run);
            end
            check("busy", {31'd0, busy}, {31'd0, eb});
            check("start_ready", {31'd0, start_ready}, {31'd0, !eb});
            check("result_valid", {31'd0, result_valid}, {31'd0, ev});
            if (ev) begin
                check("result", result, e.res);
`ifdef ALU_FLAGS_EN
                check("flags zncv", {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, e.z, e.n, e.c, e.v});
`endif
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w2,
                         input int nd, input bit sg);
        op            = o;
        word1         = a;
        word2         = w2;
        num_digits_m1 = 3'(nd);
        w2_signed     = sg;
        start_valid   = 1'b1;
    endtask

    task automatic scramble();
        word1         = $urandom;
        word2         = $urandom;
        op            = 3'($urandom);
        num_digits_m1 = 3'($urandom);
        w2_signed     = 1'($urandom);
    endtask

    task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] w2, input int nd, input bit sg,
                         input logic [31:0] lit_res, input int lit_run);
        exp_t e;
        wait_idle();
        @(posedge clk); #1;
        drive(o, a, w2, nd, sg);
        e    = model(o, a, w2, nd, sg);
        e.ac = cyc + 1;
        check({name, " model result"}, e.res, lit_res);
        check({name, " model run cycles"}, 32'(e.run), 32'(lit_run));
        q.push_back(e);
        @(posedge clk); #1;
        start_valid = 1'b0;
        scramble();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2;

        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 32'd0);
        check("reset result_valid", {31'd0, result_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset start_ready", {31'd0, start_ready}, 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        e1 = model(3'd1, 32'd125, 32'd2, 7, 1'b0);
        check("model flags sub 125-2", {28'd0, e1.z, e1.n, e1.c, e1.v}, 32'b0010);
        e1 = model(3'd1, 32'd0, 32'd1, 0, 1'b0);
        check("model flags sub 0-1", {28'd0, e1.z, e1.n, e1.c, e1.v}, 32'b0100);
        e1 = model(3'd0, 32'h7FFF_FFFF, 32'd1, 0, 1'b0);
        check("model flags add ovf", {28'd0, e1.z, e1.n, e1.c, e1.v}, 32'b0101);

        issue("add ff+4",        3'd0, 32'h0000_00FF, 32'h4,         0, 1'b0, 32'h0000_0103, 3);
        issue("add 0+800 s",     3'd0, 32'h0,         32'h800,       2, 1'b1, 32'hFFFF_F800, 8);
        issue("add 0+800 u",     3'd0, 32'h0,         32'h800,       2, 1'b0, 32'h0000_0800, 3);
        issue("sub 125-2",       3'd1, 32'd125,       32'd2,         7, 1'b0, 32'd123,       8);
        issue("sub 0-1",         3'd1, 32'd0,         32'd1,         0, 1'b0, 32'hFFFF_FFFF, 8);
        issue("add 10+f s",      3'd0, 32'h10,        32'hF,         0, 1'b1, 32'h0000_000F, 2);
        issue("add ovf",         3'd0, 32'h7FFF_FFFF, 32'h1,         0, 1'b0, 32'h8000_0000, 8);
        issue("and f0f s",       3'd2, 32'hFFFF_FFFF, 32'hF0F,       2, 1'b1, 32'hFFFF_FF0F, 3);
        issue("or 5 s",          3'd3, 32'hF000_0000, 32'h5,         0, 1'b1, 32'hF000_0005, 1);
        issue("xor ab u",        3'd4, 32'h1234_5678, 32'hFFFF_FFAB, 1, 1'b0, 32'h1234_56D3, 2);
        issue("pass2",           3'd5, 32'hDEAD_BEEF, 32'h000F_0000, 7, 1'b0, 32'h000F_0000, 1);
        issue("reserved op",     3'd6, 32'hDEAD_BEEF, 32'h1234_5678, 7, 1'b1, 32'h0,         1);

        // Back-to-back: start_valid held so the second request lands in DONE
        wait_idle();
        @(posedge clk); #1;
        drive(3'd0, 32'h0000_00FF, 32'h4, 0, 1'b0);
        e1    = model(3'd0, 32'h0000_00FF, 32'h4, 0, 1'b0);
        e1.ac = cyc + 1;
        q.push_back(e1);
        @(posedge clk); #1;
        drive(3'd1, 32'd125, 32'd2, 7, 1'b0);
        e2    = model(3'd1, 32'd125, 32'd2, 7, 1'b0);
        e2.ac = e1.ac + e1.run + 1;
        q.push_back(e2);
        repeat (e1.run + 1) @(posedge clk);
        #1;
        start_valid = 1'b0;
        scramble();

        // Reset in the middle of a run: no result pulse, outputs cleared
        issue("add before reset", 3'd1, 32'd125, 32'd2, 7, 1'b0, 32'd123, 8);
        @(posedge clk); #1;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrun reset busy", {31'd0, busy}, 32'd0);
        check("midrun reset result", result, 32'd0);
        check("midrun reset result_valid", {31'd0, result_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        issue("add after reset", 3'd0, 32'h0000_00FF, 32'h4, 0, 1'b0, 32'h0000_0103, 3);
        wait_idle();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
